// File: rtl/elevator_call_dispatcher.sv
// Collects floor call-button presses, keeps one call per floor and issues them one at a time
// to the elevator controller, choosing the next floor from the current travel direction.
module elevator_call_dispatcher #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned ISSUE_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            current_floor,
    input  logic                  elevator_direction,
    input  logic                  door_open,
    output logic [3:0]            requested_floor,
    output logic [NUM_FLOORS-1:0] call_lamp
);

    localparam int unsigned GapW = (ISSUE_GAP > 2) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GapW-1:0] GapLoad = GapW'((ISSUE_GAP > 0) ? (ISSUE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StGap
    } state_e;

    state_e                state_q, state_d;
    logic [GapW-1:0]       gap_q, gap_d;
    logic [3:0]            req_q, req_d;
    logic [NUM_FLOORS-1:0] sync1_q, sync2_q, sync3_q;
    logic [NUM_FLOORS-1:0] pend_q, pend_d;
    logic [NUM_FLOORS-1:0] iss_q, iss_d;
    logic [NUM_FLOORS-1:0] lamp_q, lamp_d;

    logic [NUM_FLOORS-1:0] rise;
    logic [NUM_FLOORS-1:0] served;
    logic [NUM_FLOORS-1:0] cand;
    logic [NUM_FLOORS-1:0] issue_vec;
    logic [3:0]            cf_eff;
    logic [3:0]            prim_sel, sec_sel, sel;
    logic                  prim_vld, sec_vld, sel_vld;
    logic                  issue;

    assign rise = sync2_q & ~sync3_q;

    always_comb begin
        served = '0;
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (door_open && current_floor == 4'(f)) begin
                served[f-1] = 1'b1;
            end
        end
    end

    assign cand   = pend_q & ~served;
    assign cf_eff = (current_floor == 4'd0 || current_floor > 4'(NUM_FLOORS)) ? 4'd1
                                                                              : current_floor;

    // Primary pick continues in the travel direction; secondary reverses when nothing is ahead.
    always_comb begin
        prim_sel = 4'd0;
        prim_vld = 1'b0;
        sec_sel  = 4'd0;
        sec_vld  = 1'b0;
        if (elevator_direction) begin
            for (int f = NUM_FLOORS; f >= 1; f--) begin
                if (cand[f-1] && 4'(f) >= cf_eff) begin
                    prim_sel = 4'(f);
                    prim_vld = 1'b1;
                end
            end
            for (int f = 1; f <= NUM_FLOORS; f++) begin
                if (cand[f-1] && 4'(f) < cf_eff) begin
                    sec_sel = 4'(f);
                    sec_vld = 1'b1;
                end
            end
        end else begin
            for (int f = 1; f <= NUM_FLOORS; f++) begin
                if (cand[f-1] && 4'(f) <= cf_eff) begin
                    prim_sel = 4'(f);
                    prim_vld = 1'b1;
                end
            end
            for (int f = NUM_FLOORS; f >= 1; f--) begin
                if (cand[f-1] && 4'(f) > cf_eff) begin
                    sec_sel = 4'(f);
                    sec_vld = 1'b1;
                end
            end
        end
        sel     = prim_vld ? prim_sel : sec_sel;
        sel_vld = prim_vld | sec_vld;
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        req_d   = 4'd0;
        issue   = 1'b0;
        case (state_q)
            StIdle: begin
                if (sel_vld) begin
                    req_d   = sel;
                    issue   = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ISSUE_GAP > 0) begin
                    state_d = StGap;
                    gap_d   = GapLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Service beats issue, issue beats a new press; presses on an issued floor are dropped.
    always_comb begin
        issue_vec = '0;
        pend_d    = pend_q;
        iss_d     = iss_q;
        for (int f = 1; f <= NUM_FLOORS; f++) begin
            if (issue && sel == 4'(f)) begin
                issue_vec[f-1] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (served[i]) begin
                pend_d[i] = 1'b0;
                iss_d[i]  = 1'b0;
            end else if (issue_vec[i]) begin
                pend_d[i] = 1'b0;
                iss_d[i]  = 1'b1;
            end else if (rise[i] && !iss_q[i]) begin
                pend_d[i] = 1'b1;
            end
        end
        lamp_d = pend_d | iss_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            pend_q  <= '0;
            iss_q   <= '0;
            lamp_q  <= '0;
            req_q   <= 4'd0;
            gap_q   <= '0;
            state_q <= StIdle;
        end else begin
            sync1_q <= call_btn;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            pend_q  <= pend_d;
            iss_q   <= iss_d;
            lamp_q  <= lamp_d;
            req_q   <= req_d;
            gap_q   <= gap_d;
            state_q <= state_d;
        end
    end

    assign requested_floor = req_q;
    assign call_lamp       = lamp_q;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Scoreboard bench for elevator_call_dispatcher: expected floors are queued when calls are
// pressed and popped by a monitor whenever a request pulse appears.
module tb_elevator_call_dispatcher;

    localparam int unsigned NF  = 8;
    localparam int unsigned GAP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] call_btn = '0;
    logic [3:0]    cf = 4'd1;
    logic          dir = 1'b1;
    logic          door = 1'b0;
    logic [3:0]    requested_floor;
    logic [NF-1:0] call_lamp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_issue = -1;
    int mon_exp;
    int exp_q[$];
    int spacing_q[$];

    elevator_call_dispatcher #(
        .NUM_FLOORS(NF),
        .ISSUE_GAP (GAP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .call_btn          (call_btn),
        .current_floor     (cf),
        .elevator_direction(dir),
        .door_open         (door),
        .requested_floor   (requested_floor),
        .call_lamp         (call_lamp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Every request pulse must match the oldest expected floor and respect the minimum spacing.
    always @(negedge clk) begin
        if (!rst && requested_floor !== 4'd0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got floor %0d, required no request",
                         requested_floor);
            end else begin
                mon_exp = exp_q.pop_front();
                if (requested_floor !== 4'(mon_exp)) begin
                    errors++;
                    $display("FAIL issue_order: got floor %0d, required %0d",
                             requested_floor, mon_exp);
                end
            end
            if (last_issue >= 0) begin
                spacing_q.push_back(cyc - last_issue);
                checks++;
                if (cyc - last_issue < int'(GAP + 2)) begin
                    errors++;
                    $display("FAIL issue_spacing: got %0d cycles, required >= %0d",
                             cyc - last_issue, GAP + 2);
                end
            end
            last_issue = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d issues outstanding after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic serve_all();
        for (int f = 1; f <= int'(NF); f++) begin
            cf   = 4'(f);
            door = 1'b1;
            tick();
        end
        door = 1'b0;
        cf   = 4'd1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        call_btn = '1;
        repeat (2) begin
            tick();
            checks += 2;
            if (requested_floor !== 4'd0) begin
                errors++;
                $display("FAIL reset_req: got %0d, required 0", requested_floor);
            end
            if (call_lamp !== '0) begin
                errors++;
                $display("FAIL reset_lamp: got %b, required 0", call_lamp);
            end
        end
        call_btn = '0;
        rst      = 1'b0;
        repeat (6) tick();
        checks++;
        if (call_lamp !== '0) begin
            errors++;
            $display("FAIL reset_idle_lamp: got %b, required 0", call_lamp);
        end
    endtask

    task automatic test_single_call();
        cf          = 4'd1;
        dir         = 1'b1;
        door        = 1'b0;
        last_issue  = -1;
        call_btn[2] = 1'b1;
        exp_q.push_back(3);
        repeat (2) tick();
        checks++;
        if (call_lamp[2] !== 1'b0) begin
            errors++;
            $display("FAIL single_lamp_early: got %b, required 0 at k+2", call_lamp[2]);
        end
        tick();
        checks += 2;
        if (call_lamp[2] !== 1'b1) begin
            errors++;
            $display("FAIL single_lamp_on: got %b, required 1 at k+3", call_lamp[2]);
        end
        if (requested_floor !== 4'd0) begin
            errors++;
            $display("FAIL single_req_early: got %0d, required 0 at k+3", requested_floor);
        end
        tick();
        checks++;
        if (requested_floor !== 4'd3) begin
            errors++;
            $display("FAIL single_req: got %0d, required 3 at k+4", requested_floor);
        end
        tick();
        checks++;
        if (requested_floor !== 4'd0) begin
            errors++;
            $display("FAIL single_req_pulse: got %0d, required 0 at k+5", requested_floor);
        end
        call_btn = '0;
        repeat (10) tick();
        checks++;
        if (call_lamp[2] !== 1'b1) begin
            errors++;
            $display("FAIL single_lamp_held: got %b, required 1", call_lamp[2]);
        end
        cf   = 4'd3;
        door = 1'b1;
        tick();
        checks++;
        if (call_lamp[2] !== 1'b0) begin
            errors++;
            $display("FAIL single_lamp_served: got %b, required 0", call_lamp[2]);
        end
        door = 1'b0;
        cf   = 4'd1;
        wait_drain(2, "single");
        repeat (GAP + 2) tick();
    endtask

    task automatic test_direction(input logic d, input int a, input int b, input int c);
        cf         = 4'd4;
        dir        = d;
        door       = 1'b0;
        last_issue = -1;
        spacing_q.delete();
        call_btn = 8'b0110_0010;
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        repeat (3) tick();
        call_btn = '0;
        wait_drain(40, "direction");
        checks++;
        if (spacing_q.size() != 2 || spacing_q[0] != int'(GAP + 2) ||
            spacing_q[1] != int'(GAP + 2)) begin
            errors++;
            $display("FAIL direction_spacing: got %p, required two gaps of %0d",
                     spacing_q, GAP + 2);
        end
        serve_all();
        repeat (GAP + 2) tick();
    endtask

    task automatic test_served_same_cycle();
        cf          = 4'd1;
        dir         = 1'b1;
        door        = 1'b0;
        call_btn[5] = 1'b1;
        repeat (3) tick();
        call_btn = '0;
        checks++;
        if (call_lamp[5] !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_lamp_on: got %b, required 1", call_lamp[5]);
        end
        cf   = 4'd6;
        door = 1'b1;
        tick();
        checks += 2;
        if (requested_floor !== 4'd0) begin
            errors++;
            $display("FAIL same_cycle_req: got %0d, required 0", requested_floor);
        end
        if (call_lamp[5] !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_lamp_off: got %b, required 0", call_lamp[5]);
        end
        door = 1'b0;
        cf   = 4'd1;
        repeat (8) tick();
    endtask

    task automatic test_served_before_issue();
        cf          = 4'd1;
        dir         = 1'b1;
        door        = 1'b0;
        call_btn[1] = 1'b1;
        call_btn[4] = 1'b1;
        exp_q.push_back(2);
        repeat (3) tick();
        call_btn = '0;
        repeat (2) tick();
        cf   = 4'd5;
        door = 1'b1;
        tick();
        checks += 2;
        if (call_lamp[4] !== 1'b0) begin
            errors++;
            $display("FAIL served_lamp5: got %b, required 0", call_lamp[4]);
        end
        if (call_lamp[1] !== 1'b1) begin
            errors++;
            $display("FAIL served_lamp2: got %b, required 1", call_lamp[1]);
        end
        door = 1'b0;
        cf   = 4'd1;
        repeat (12) tick();
        wait_drain(2, "served");
        serve_all();
        repeat (GAP + 2) tick();
    endtask

    task automatic test_duplicate();
        cf          = 4'd1;
        dir         = 1'b1;
        door        = 1'b0;
        call_btn[3] = 1'b1;
        exp_q.push_back(4);
        repeat (3) tick();
        call_btn = '0;
        wait_drain(10, "duplicate");
        repeat (2) tick();
        call_btn[3] = 1'b1;
        repeat (4) tick();
        call_btn = '0;
        repeat (12) tick();
        checks++;
        if (call_lamp[3] !== 1'b1) begin
            errors++;
            $display("FAIL duplicate_lamp: got %b, required 1", call_lamp[3]);
        end
        cf   = 4'd4;
        door = 1'b1;
        tick();
        checks++;
        if (call_lamp[3] !== 1'b0) begin
            errors++;
            $display("FAIL duplicate_served: got %b, required 0", call_lamp[3]);
        end
        door = 1'b0;
        cf   = 4'd1;
        repeat (GAP + 2) tick();
    endtask

    task automatic test_back_to_back();
        cf         = 4'd1;
        dir        = 1'b1;
        door       = 1'b0;
        last_issue = -1;
        spacing_q.delete();
        call_btn = '1;
        for (int f = 1; f <= int'(NF); f++) exp_q.push_back(f);
        repeat (3) tick();
        call_btn = '0;
        wait_drain(80, "all_floors");
        checks += 2;
        if (spacing_q.size() != int'(NF - 1) || spacing_q.max() != spacing_q.min() ||
            spacing_q[0] != int'(GAP + 2)) begin
            errors++;
            $display("FAIL all_floors_spacing: got %p, required %0d gaps of %0d",
                     spacing_q, NF - 1, GAP + 2);
        end
        if (call_lamp !== '1) begin
            errors++;
            $display("FAIL all_floors_lamps: got %b, required all 1", call_lamp);
        end
        serve_all();
        repeat (GAP + 2) tick();
        checks++;
        if (call_lamp !== '0) begin
            errors++;
            $display("FAIL all_floors_cleared: got %b, required 0", call_lamp);
        end
    endtask

    task automatic test_reset_mid_drain();
        cf       = 4'd1;
        dir      = 1'b1;
        door     = 1'b0;
        call_btn = 8'b0101_0100;
        exp_q.push_back(3);
        repeat (3) tick();
        call_btn = '0;
        wait_drain(10, "mid_reset");
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 2;
        if (call_lamp !== '0) begin
            errors++;
            $display("FAIL mid_reset_lamp: got %b, required 0", call_lamp);
        end
        if (requested_floor !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset_req: got %0d, required 0", requested_floor);
        end
        repeat (20) tick();
        checks++;
        if (call_lamp !== '0) begin
            errors++;
            $display("FAIL mid_reset_quiet: got %b, required 0", call_lamp);
        end
        last_issue  = -1;
        call_btn[7] = 1'b1;
        exp_q.push_back(8);
        repeat (4) tick();
        call_btn = '0;
        checks++;
        if (requested_floor !== 4'd8) begin
            errors++;
            $display("FAIL mid_reset_new_call: got %0d, required 8 at k+4", requested_floor);
        end
        wait_drain(2, "mid_reset_new");
        serve_all();
        repeat (GAP + 2) tick();
    endtask

    initial begin
        test_reset();
        test_single_call();
        test_direction(1'b1, 6, 7, 2);
        test_direction(1'b0, 2, 6, 7);
        test_served_same_cycle();
        test_served_before_issue();
        test_duplicate();
        test_back_to_back();
        test_reset_mid_drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
